// File: rtl/zylo_note_feeder_if.sv
// Avalon-MM write-only bus between the note feeder (master) and the VGA sprite peripheral (slave).
interface zylo_note_feeder_if;
  logic [15:0] avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write;
  logic        avm_chipselect;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_writedata, avm_write, avm_chipselect,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_writedata, avm_write, avm_chipselect,
    output avm_waitrequest
  );
endinterface

// File: rtl/zylo_note_feeder.sv
// Shadows 64 note sprites plus a score word and flushes dirty state as Avalon writes each vblank.
// Define ZYLO_SCROLL_EN to advance every live sprite by scroll_step per frame and retire it at Y_LIMIT.
module zylo_note_feeder #(
  parameter logic [15:0] SCORE_ADDR = 16'h0004,
  parameter logic [15:0] NOTE_ADDR  = 16'h0006
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  input  logic [5:0]  upd_index_i,
  input  logic [5:0]  upd_n_i,
  input  logic [9:0]  upd_x_i,
  input  logic [9:0]  upd_y_i,
  input  logic        score_valid_i,
  input  logic [15:0] score_i,
  input  logic [15:0] combo_i,
  input  logic [3:0]  scroll_step_i,
  input  logic        frame_start_i,
  output logic        busy_o,
  output logic        overrun_o,
  zylo_note_feeder_if.master avm
);

  localparam int unsigned NUM_NOTES = 64;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned N_W       = 6;
  localparam int unsigned C_W       = 10;
`ifdef ZYLO_SCROLL_EN
  localparam int unsigned Y_LIMIT   = 480;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCORE = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_NOTES-1:0] dirty_q, dirty_d;
  logic                 pend_q, pend_d;
  logic [15:0]          score_q, score_d, combo_q, combo_d;
  logic [N_W-1:0]       n_q [NUM_NOTES];
  logic [C_W-1:0]       x_q [NUM_NOTES];
  logic [C_W-1:0]       y_q [NUM_NOTES];
  logic [N_W-1:0]       hold_n_q, hold_n_d;
  logic [C_W-1:0]       hold_y_q, hold_y_d;
  logic [15:0]          addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic                 write_q, write_d;
  logic                 busy_q, overrun_q, overrun_d;

  logic                 tbl_we;
  logic [IDX_W-1:0]     tbl_idx;
  logic [N_W-1:0]       tbl_n, pk_n;
  logic [C_W-1:0]       tbl_x, tbl_y, pk_y;
`ifdef ZYLO_SCROLL_EN
  logic [C_W:0]         ny;
`else
  logic                 unused_scroll;
  assign unused_scroll = ^scroll_step_i;
`endif

  assign upd_ready_o        = !busy_q;
  assign busy_o             = busy_q;
  assign overrun_o          = overrun_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = data_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_chipselect = write_q;

  // Next-state, table write port and registered bus outputs
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    pend_d    = pend_q;
    score_d   = score_q;
    combo_d   = combo_q;
    hold_n_d  = hold_n_q;
    hold_y_d  = hold_y_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = (state_q != S_IDLE) && frame_start_i;
    tbl_we    = 1'b0;
    tbl_idx   = upd_index_i;
    tbl_n     = upd_n_i;
    tbl_x     = upd_x_i;
    tbl_y     = upd_y_i;

    // Packet for the entry under scan; frozen into hold_* once the write starts
    pk_n = n_q[idx_q];
    pk_y = y_q[idx_q];
`ifdef ZYLO_SCROLL_EN
    ny = {1'b0, y_q[idx_q]} + (C_W+1)'(scroll_step_i);
    if (pk_n != '0) begin
      if (ny < (C_W+1)'(Y_LIMIT)) begin
        pk_y = ny[C_W-1:0];
      end else begin
        pk_n = '0;
        pk_y = '0;
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
`ifdef ZYLO_SCROLL_EN
          for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            if (n_q[i] != '0) dirty_d[i] = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = pend_q ? S_SCORE : S_SCAN;
        end
        if (upd_valid_i) begin
          tbl_we               = 1'b1;
          dirty_d[upd_index_i] = 1'b1;
        end
      end
      S_SCORE: begin
        if (!avm.avm_waitrequest) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (dirty_q[idx_q]) begin
          state_d = S_WRITE;
        end else begin
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          state_d = (idx_q == IDX_W'(NUM_NOTES - 1)) ? S_IDLE : S_SCAN;
        end
      end
      default: begin
        if (!avm.avm_waitrequest) begin
          dirty_d[idx_q] = 1'b0;
          tbl_we         = 1'b1;
          tbl_idx        = idx_q;
          tbl_n          = hold_n_q;
          tbl_x          = x_q[idx_q];
          tbl_y          = hold_y_q;
          idx_d          = IDX_W'(idx_q + IDX_W'(1));
          state_d        = (idx_q == IDX_W'(NUM_NOTES - 1)) ? S_IDLE : S_SCAN;
        end
      end
    endcase

    if (score_valid_i) begin
      pend_d  = 1'b1;
      score_d = score_i;
      combo_d = combo_i;
    end

    write_d = (state_d == S_SCORE) || (state_d == S_WRITE);
    if ((state_d == S_SCORE) && (state_q != S_SCORE)) begin
      addr_d = SCORE_ADDR;
      data_d = {combo_q, score_q};
    end
    if ((state_d == S_WRITE) && (state_q != S_WRITE)) begin
      addr_d   = NOTE_ADDR;
      data_d   = {idx_q, pk_n, pk_y, x_q[idx_q]};
      hold_n_d = pk_n;
      hold_y_d = pk_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      dirty_q   <= '0;
      pend_q    <= 1'b0;
      score_q   <= '0;
      combo_q   <= '0;
      hold_n_q  <= '0;
      hold_y_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      pend_q    <= pend_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      hold_n_q  <= hold_n_d;
      hold_y_q  <= hold_y_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= (state_d != S_IDLE);
      overrun_q <= overrun_d;
    end
  end

  // Sprite shadow table
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
        n_q[i] <= '0;
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (tbl_we) begin
      n_q[tbl_idx] <= tbl_n;
      x_q[tbl_idx] <= tbl_x;
      y_q[tbl_idx] <= tbl_y;
    end
  end

endmodule

// File: tb/tb_zylo_note_feeder.sv
// Scoreboard bench for zylo_note_feeder: a frame-level table model predicts every bus write.
module tb_zylo_note_feeder;

  logic        clk;
  logic        reset;
  logic        upd_valid, upd_ready;
  logic [5:0]  upd_index, upd_n;
  logic [9:0]  upd_x, upd_y;
  logic        score_valid;
  logic [15:0] score_in, combo_in;
  logic [3:0]  scroll_step;
  logic        frame_start;
  logic        busy, overrun;

  zylo_note_feeder_if bus ();

  zylo_note_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .upd_valid_i   (upd_valid),
    .upd_ready_o   (upd_ready),
    .upd_index_i   (upd_index),
    .upd_n_i       (upd_n),
    .upd_x_i       (upd_x),
    .upd_y_i       (upd_y),
    .score_valid_i (score_valid),
    .score_i       (score_in),
    .combo_i       (combo_in),
    .scroll_step_i (scroll_step),
    .frame_start_i (frame_start),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .avm           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: plain arrays describing what the peripheral should end up seeing
  logic [5:0]  m_n [64];
  logic [9:0]  m_x [64];
  logic [9:0]  m_y [64];
  bit          m_dirty [64];
  bit          m_pend;
  logic [15:0] m_score, m_combo;
  logic [47:0] exp_q [$];

  // Observed transfers
  logic [47:0] log_q [$];
  int          run_q [$];
  int          xfer_cnt = 0;
  int          stall_cnt = 0;
  int          ovr_cnt = 0;

  // Waitrequest control
  bit wait_rand = 1'b0;
  int force_len = 0;
  int force_gen = 0;
  int drv_gen = 0;
  int drv_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pkt(input logic [5:0] i, input logic [5:0] n,
                                      input logic [9:0] y, input logic [9:0] x);
    return {i, n, y, x};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_n[i] = '0; m_x[i] = '0; m_y[i] = '0; m_dirty[i] = 1'b0;
    end
    m_pend = 1'b0; m_score = '0; m_combo = '0;
  endfunction

  // Whole-frame prediction; returns the number of bus writes the flush must make
  function automatic int model_flush(input logic [3:0] step);
    int cnt = 0;
    int ny;
`ifdef ZYLO_SCROLL_EN
    for (int i = 0; i < 64; i++) if (m_n[i] != 0) m_dirty[i] = 1'b1;
`endif
    if (m_pend) begin
      exp_q.push_back({16'h0004, m_combo, m_score});
      m_pend = 1'b0;
      cnt++;
    end
    for (int i = 0; i < 64; i++) begin
      if (m_dirty[i]) begin
`ifdef ZYLO_SCROLL_EN
        if (m_n[i] != 0) begin
          ny = int'(m_y[i]) + int'(step);
          if (ny < 480) m_y[i] = 10'(ny);
          else begin m_n[i] = '0; m_y[i] = '0; end
        end
`else
        ny = int'(step);
`endif
        exp_q.push_back({16'h0006, pkt(6'(i), m_n[i], m_y[i], m_x[i])});
        m_dirty[i] = 1'b0;
        cnt++;
      end
    end
    return cnt;
  endfunction

  // Slave side: forced stall bursts or random stalls
  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (force_gen != drv_gen && bus.avm_write) begin
        drv_gen  = force_gen;
        drv_left = force_len;
      end
      if (drv_left > 0) begin
        bus.avm_waitrequest = 1'b1;
        drv_left--;
      end else begin
        bus.avm_waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted transfer, checks hold stability
  initial begin
    bit          prev_stall = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pdata = '0;
    int          run = 0;
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        run = 0;
      end else begin
        if (bus.avm_write || bus.avm_chipselect)
          chk("chipselect_eq_write", 32'(bus.avm_chipselect), 32'(bus.avm_write));
        if (prev_stall) begin
          chk("hold_write", 32'(bus.avm_write), 32'd1);
          chk("hold_addr", 32'(bus.avm_address), 32'(paddr));
          chk("hold_data", bus.avm_writedata, pdata);
        end
        run = bus.avm_write ? run + 1 : 0;
        if (bus.avm_write && !bus.avm_waitrequest) begin
          xfer_cnt++;
          log_q.push_back({bus.avm_address, bus.avm_writedata});
          run_q.push_back(run);
          if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", 32'(bus.avm_address), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_addr", 32'(bus.avm_address), 32'(e[47:32]));
            chk("sb_data", bus.avm_writedata, e[31:0]);
          end
        end
        if (bus.avm_write && bus.avm_waitrequest) stall_cnt++;
        if (overrun) ovr_cnt++;
        prev_stall = bus.avm_write && bus.avm_waitrequest;
        paddr = bus.avm_address;
        pdata = bus.avm_writedata;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  task automatic do_update(input logic [5:0] i, input logic [5:0] n,
                           input logic [9:0] x, input logic [9:0] y);
    @(posedge clk); #1;
    chk("upd_ready_idle", 32'(upd_ready), 32'd1);
    upd_valid = 1'b1; upd_index = i; upd_n = n; upd_x = x; upd_y = y;
    m_n[i] = n; m_x[i] = x; m_y[i] = y; m_dirty[i] = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic do_score(input logic [15:0] s, input logic [15:0] c);
    @(posedge clk); #1;
    score_valid = 1'b1; score_in = s; combo_in = c;
    m_pend = 1'b1; m_score = s; m_combo = c;
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  // Issues one frame (optionally with a coinciding update and a mid-flush frame_start)
  task automatic do_frame(input logic [3:0] step, input int inject, input bit coin,
                          input logic [5:0] ci, input logic [5:0] cn,
                          input logic [9:0] cx, input logic [9:0] cy);
    int k, cyc, st0, ov0;
    scroll_step = step;
    @(posedge clk); #1;
    frame_start = 1'b1;
    if (coin) begin
      upd_valid = 1'b1; upd_index = ci; upd_n = cn; upd_x = cx; upd_y = cy;
      m_n[ci] = cn; m_x[ci] = cx; m_y[ci] = cy; m_dirty[ci] = 1'b1;
    end
    k = model_flush(step);
    st0 = stall_cnt;
    ov0 = ovr_cnt;
    @(posedge clk); #1;
    frame_start = 1'b0;
    upd_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 2000) begin
      cyc++;
      frame_start = (cyc == inject);
      @(negedge clk);
    end
    frame_start = 1'b0;
    #1;
    chk("busy_len", 32'(cyc), 32'(64 + k + (stall_cnt - st0)));
    chk("overrun_pulses", 32'(ovr_cnt - ov0), (inject > 0) ? 32'd1 : 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int x0, cyc, nu;
    reset = 1'b1;
    upd_valid = 1'b0; upd_index = '0; upd_n = '0; upd_x = '0; upd_y = '0;
    score_valid = 1'b0; score_in = '0; combo_in = '0;
    scroll_step = '0; frame_start = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_upd_ready", 32'(upd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_write", 32'(bus.avm_write), 32'd0);
    chk("rst_chipselect", 32'(bus.avm_chipselect), 32'd0);
    chk("rst_address", 32'(bus.avm_address), 32'd0);
    chk("rst_writedata", bus.avm_writedata, 32'd0);

    // Empty table: 64 scan cycles, no writes
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("empty_no_write", 32'(xfer_cnt - x0), 32'd0);

`ifndef ZYLO_SCROLL_EN
    do_update(6'd5, 6'd3, 10'd100, 10'd20);
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("single_write_count", 32'(xfer_cnt - x0), 32'd1);
    chk("single_write_addr", 32'(log_q[x0][47:32]), 32'h0000_0006);
    chk("single_write_data", log_q[x0][31:0], 32'h1430_5064);
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("second_frame_quiet", 32'(xfer_cnt - x0), 32'd0);

    do_score(16'h0012, 16'h0003);
    do_update(6'd63, 6'd9, 10'd1, 10'd2);
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("score_first_addr", 32'(log_q[x0][47:32]), 32'h0000_0004);
    chk("score_first_data", log_q[x0][31:0], 32'h0003_0012);

    do_update(6'd9, 6'd7, 10'd33, 10'd44);
    force_len = 3;
    force_gen++;
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("wait_one_transfer", 32'(xfer_cnt - x0), 32'd1);
    chk("wait_hold_cycles", 32'(run_q[run_q.size()-1]), 32'd4);
    x0 = xfer_cnt;
    do_frame(4'd0, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("wait_dirty_cleared", 32'(xfer_cnt - x0), 32'd0);

    do_update(6'd12, 6'd2, 10'd300, 10'd400);
    x0 = xfer_cnt;
    do_frame(4'd0, 10, 1'b1, 6'd50, 6'd4, 10'd5, 10'd6);
    chk("overrun_coincide_count", 32'(xfer_cnt - x0), 32'd2);
`else
    do_update(6'd0, 6'd1, 10'd7, 10'd470);
    x0 = xfer_cnt;
    do_frame(4'd8, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("scroll_f1_count", 32'(xfer_cnt - x0), 32'd1);
    chk("scroll_f1_data", log_q[x0][31:0], pkt(6'd0, 6'd1, 10'd478, 10'd7));
    x0 = xfer_cnt;
    do_frame(4'd8, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("scroll_f2_count", 32'(xfer_cnt - x0), 32'd1);
    chk("scroll_f2_data", log_q[x0][31:0], pkt(6'd0, 6'd0, 10'd0, 10'd7));
    x0 = xfer_cnt;
    do_frame(4'd8, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("scroll_f3_quiet", 32'(xfer_cnt - x0), 32'd0);
`endif

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      wait_rand = ($urandom_range(0, 1) == 1);
      nu = $urandom_range(0, 5);
      for (int u = 0; u < nu; u++)
        do_update(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1) == 1)
        do_score(16'($urandom), 16'($urandom));
      do_frame(4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0,
               ($urandom_range(0, 3) == 0),
               6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    end
    wait_rand = 1'b0;

    // Reset in the middle of a flush aborts it
    do_update(6'd10, 6'd1, 10'd11, 10'd12);
    do_update(6'd20, 6'd2, 10'd21, 10'd22);
    do_update(6'd30, 6'd3, 10'd31, 10'd32);
    do_update(6'd40, 6'd4, 10'd41, 10'd42);
    x0 = xfer_cnt;
    @(posedge clk); #1;
    frame_start = 1'b1;
    nu = model_flush(scroll_step);
    @(posedge clk); #1;
    frame_start = 1'b0;
    cyc = 0;
    @(negedge clk); #1;
    while (!(xfer_cnt > x0 && busy && !bus.avm_write) && cyc < 1000) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("midflush_reached", 32'(cyc < 1000), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_write", 32'(bus.avm_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_upd_ready", 32'(upd_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    x0 = xfer_cnt;
    repeat (100) @(negedge clk);
    chk("midrst_no_more_writes", 32'(xfer_cnt - x0), 32'd0);
    x0 = xfer_cnt;
    do_frame(4'd3, 0, 1'b0, 6'd0, 6'd0, 10'd0, 10'd0);
    chk("midrst_table_cleared", 32'(xfer_cnt - x0), 32'd0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
